fetch_address_generator: RTL and testbench

- Instruction-fetch address stage of the 5-stage MIPS pipeline (IF).
- Each cycle it selects the fetch address: the branch target when PCSrc is high, otherwise the sequential PC in address_in.
- It registers the next PC on address_out. The next PC advances by one instruction only when the instruction cache reports a hit; on a miss the same address is replayed.
- address_out feeds back externally into address_in through the pipeline's PC path.

---
 rtl/mips_pkg.sv | 10 +
 rtl/pc_incrementer.sv | 13 +
 rtl/fetch_address_generator.sv | 65 ++++++
 tb/tb_fetch_address_generator.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: address width, PC increment and reset vector.
package mips_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational PC adder: addr + INSTR_BYTES, wrapping modulo 2^ADDR_W.
module pc_incrementer #(
  parameter int unsigned ADDR_W      = mips_pkg::ADDR_W,
  parameter int unsigned INSTR_BYTES = mips_pkg::INSTR_BYTES
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Carry out of the top bit is dropped so the PC wraps to zero.
  assign addr_o = addr_i + ADDR_W'(INSTR_BYTES);

endmodule

// File: rtl/fetch_address_generator.sv
// IF-stage fetch address select and next-PC register with miss replay.
// Optional alignment fault flag enabled by defining FAG_ALIGN_CHECK_EN.
module fetch_address_generator #(
  parameter int unsigned ADDR_W      = mips_pkg::ADDR_W,
  parameter int unsigned INSTR_BYTES = mips_pkg::INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(mips_pkg::RESET_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hit,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] address_branch,
  input  logic [ADDR_W-1:0] address_in,
  output logic [ADDR_W-1:0] instruction_address,
  output logic [ADDR_W-1:0] address_out,
  output logic              misaligned
);

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] address_out_d;
  logic [ADDR_W-1:0] address_out_q;

  assign instruction_address = PCSrc ? address_branch : address_in;

  pc_incrementer #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_incrementer (
    .addr_i (instruction_address),
    .addr_o (addr_inc)
  );

  // A miss replays the same fetch, which also keeps a held branch target.
  assign address_out_d = hit ? addr_inc : instruction_address;

  always_ff @(posedge clk) begin
    if (reset) begin
      address_out_q <= RESET_ADDR;
    end else begin
      address_out_q <= address_out_d;
    end
  end

  assign address_out = address_out_q;

`ifdef FAG_ALIGN_CHECK_EN
  logic misaligned_d;
  logic misaligned_q;

  assign misaligned_d = (instruction_address[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_address_generator.sv
// Self-checking bench for fetch_address_generator: directed plan plus randomized
// stimulus compared every cycle against a behavioural next-PC model.
module tb_fetch_address_generator;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          reset;
  logic          hit;
  logic          PCSrc;
  logic [AW-1:0] address_branch;
  logic [AW-1:0] address_in;
  logic [AW-1:0] instruction_address;
  logic [AW-1:0] address_out;
  logic          misaligned;

  int checks   = 0;
  int failures = 0;

  // Model state: what address_out / misaligned must hold after the last edge.
  logic [AW-1:0] m_out;
  logic          m_mis;

  fetch_address_generator dut (
    .clk                 (clk),
    .reset               (reset),
    .hit                 (hit),
    .PCSrc               (PCSrc),
    .address_branch      (address_branch),
    .address_in          (address_in),
    .instruction_address (instruction_address),
    .address_out         (address_out),
    .misaligned          (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; check the combinational path, clock, then check state.
  task automatic step(input logic r, input logic h, input logic pc,
                      input logic [AW-1:0] br, input logic [AW-1:0] ain);
    logic [AW-1:0] ia;
    logic [AW-1:0] nxt;
    logic          mis;
    reset          = r;
    hit            = h;
    PCSrc          = pc;
    address_branch = br;
    address_in     = ain;
    ia  = pc ? br : ain;
    nxt = h ? ia + 32'd4 : ia;
`ifdef FAG_ALIGN_CHECK_EN
    mis = (ia % 4) != 0;
`else
    mis = 1'b0;
`endif
    #1;
    chk("instruction_address", instruction_address, ia);
    @(posedge clk);
    m_out = r ? 32'h0000_0000 : nxt;
    m_mis = r ? 1'b0 : mis;
    #1;
    chk("address_out", address_out, m_out);
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  initial begin
    logic          r;
    logic          h;
    logic          pc;
    logic [AW-1:0] br;
    logic [AW-1:0] ain;
    reset = 1'b1; hit = 1'b0; PCSrc = 1'b0; address_branch = '0; address_in = '0;
    m_out = '0; m_mis = 1'b0;
    @(posedge clk);
    #1;

    // 1. Reset held two cycles while inputs would otherwise advance the PC.
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h40);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'h40);
    chk("reset_out", address_out, 32'h0);
    chk("reset_mis", {31'd0, misaligned}, 32'h0);

    // 2. Miss stall replays address 0.
    step(1'b0, 1'b0, 1'b0, 32'd10, 32'h0);
    chk("stall_ia", instruction_address, 32'h0);
    chk("stall_out", address_out, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'd10, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'd10, 32'h0);
    chk("stall_out_held", address_out, 32'h0);

    // 3. Sequential hit.
    step(1'b0, 1'b1, 1'b0, 32'd10, 32'h0);
    chk("seq_out", address_out, 32'h4);

    // 4. Branch taken on hit to an unaligned target.
    step(1'b0, 1'b1, 1'b1, 32'd10, 32'h4);
    chk("br_ia", instruction_address, 32'd10);
    chk("br_out", address_out, 32'd14);
`ifdef FAG_ALIGN_CHECK_EN
    chk("br_mis", {31'd0, misaligned}, 32'h1);
`else
    chk("br_mis", {31'd0, misaligned}, 32'h0);
`endif

    // 5. Branch on miss keeps the target un-incremented, then release.
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'h14);
    chk("brmiss_out", address_out, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h100, 32'h4);
    chk("release_ia", instruction_address, 32'h4);
    chk("release_out", address_out, 32'h8);

    // 6. Wrap-around, then reset during a stall.
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    chk("wrap_out", address_out, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    chk("stall_pre_reset", address_out, 32'h200);
    step(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
    chk("midstall_reset", address_out, 32'h0);

    // Randomized traffic: address_in mostly follows the fed-back PC.
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      h  = $urandom_range(0, 3) != 0;
      pc = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       br = 32'hFFFF_FFFC;
        1:       br = $urandom();
        default: br = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      endcase
      ain = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : m_out;
      step(r, h, pc, br, ain);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
